pattern_loader: RTL and testbench

//  Writer side of the pattern memory: the pattern sequencer reads 16-bit words; this block fills the RAM.

---
 rtl/pattern_loader_pkg.sv | 28 ++
 rtl/pattern_loader_timeout.sv | 36 +++
 rtl/pattern_loader.sv | 160 ++++++++++++++++
 tb/tb_pattern_loader.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pattern_loader_pkg.sv
// Shared types for the pattern RAM loader: FSM states, error codes and
// the frame word-count decode.
package pattern_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ADDR    = 3'd1,
      ST_COUNT   = 3'd2,
      ST_DATA_HI = 3'd3,
      ST_DATA_LO = 3'd4,
      ST_CHK     = 3'd5
   } state_e;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_CHECKSUM = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

   // COUNT=0 encodes a full frame: 256 words, or the RAM depth if smaller.
   function automatic logic [8:0] frame_words(
      input logic [7:0]  count,
      input int unsigned aw
   );
      logic [8:0] full;
      full = (aw >= 8) ? 9'd256 : 9'(1 << aw);
      return (count == 8'd0) ? full : {1'b0, count};
   endfunction

endpackage

// File: rtl/pattern_loader_timeout.sv
// Inter-byte watchdog: counts idle clocks while enabled and flags the
// cycle in which the count reaches TIMEOUT_CYCLES-1 without a clear.
module loader_timeout #(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign o_expired = i_enable && !i_clear && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (i_clear || !i_enable || o_expired) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pattern_loader.sv
// Parses framed load commands from a byte stream into pattern RAM writes,
// holding playback off (o_busy) while a frame is in flight.
module pattern_loader
   import pattern_loader_pkg::*;
#(
   parameter int         ADDR_WIDTH     = 8,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [7:0]            i_byte,
   input  logic                  i_byte_valid,
   output logic                  o_wr_en,
   output logic [ADDR_WIDTH-1:0] o_wr_addr,
   output logic [15:0]           o_wr_data,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error,
   output logic [1:0]            o_error_code
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [8:0]            cnt_q, cnt_d;
   logic [7:0]            hi_q, hi_d;
   logic [7:0]            sum_q, sum_d;
   logic [7:0]            sum_nxt;

   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [15:0]           wr_data_q, wr_data_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [1:0]            code_q, code_d;

   logic                  expired;

   loader_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clear  (i_byte_valid),
      .i_enable (state_q != ST_IDLE),
      .o_expired(expired)
   );

   assign sum_nxt = sum_q + i_byte;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      sum_d     = sum_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      code_d    = code_q;

      if (i_byte_valid) begin
         unique case (state_q)
            ST_IDLE: begin
               if (i_byte == SYNC_BYTE) begin
                  state_d = ST_ADDR;
                  busy_d  = 1'b1;
                  sum_d   = 8'd0;
               end
            end
            ST_ADDR: begin
               ptr_d   = ADDR_WIDTH'(i_byte);
               sum_d   = sum_nxt;
               state_d = ST_COUNT;
            end
            ST_COUNT: begin
               cnt_d   = frame_words(i_byte, ADDR_WIDTH);
               sum_d   = sum_nxt;
               state_d = ST_DATA_HI;
            end
            ST_DATA_HI: begin
               hi_d    = i_byte;
               sum_d   = sum_nxt;
               state_d = ST_DATA_LO;
            end
            ST_DATA_LO: begin
               wr_en_d   = 1'b1;
               wr_addr_d = ptr_q;
               wr_data_d = {hi_q, i_byte};
               ptr_d     = ptr_q + 1'b1;
               cnt_d     = cnt_q - 9'd1;
               sum_d     = sum_nxt;
               state_d   = (cnt_q == 9'd1) ? ST_CHK : ST_DATA_HI;
            end
            ST_CHK: begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               if (sum_nxt == 8'd0) begin
                  done_d = 1'b1;
               end else begin
                  err_d  = 1'b1;
                  code_d = ERR_CHECKSUM;
               end
            end
            default: begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end else if (expired) begin
         state_d = ST_IDLE;
         busy_d  = 1'b0;
         err_d   = 1'b1;
         code_d  = ERR_TIMEOUT;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         cnt_q     <= '0;
         hi_q      <= '0;
         sum_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         code_q    <= ERR_NONE;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         sum_q     <= sum_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         code_q    <= code_d;
      end
   end

   assign o_wr_en      = wr_en_q;
   assign o_wr_addr    = wr_addr_q;
   assign o_wr_data    = wr_data_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_error      = err_q;
   assign o_error_code = code_q;

endmodule

// File: tb/tb_pattern_loader.sv
// Cycle-table bench for pattern_loader: each row drives one clock of
// inputs and lists the registered outputs expected after that edge.
module tb_pattern_loader;
   import pattern_loader_pkg::*;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  byt;
   logic        bv;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [15:0] wr_data;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  code;

   typedef struct {
      logic        rst;
      logic        v;
      logic [7:0]  b;
      logic        wen;
      logic [7:0]  addr;
      logic [15:0] data;
      logic        busy;
      logic        done;
      logic        err;
      logic [1:0]  code;
   } vec_t;

   vec_t       vecs[$];
   logic [1:0] ec;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   pattern_loader #(
      .ADDR_WIDTH    (8),
      .SYNC_BYTE     (8'hA5),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_byte      (byt),
      .i_byte_valid(bv),
      .o_wr_en     (wr_en),
      .o_wr_addr   (wr_addr),
      .o_wr_data   (wr_data),
      .o_busy      (busy),
      .o_done      (done),
      .o_error     (err),
      .o_error_code(code)
   );

   task automatic add(input logic r, input logic v, input logic [7:0] b,
                      input logic wen, input logic [7:0] a,
                      input logic [15:0] d, input logic bs,
                      input logic dn, input logic er);
      vec_t e;
      e.rst = r; e.v = v; e.b = b; e.wen = wen; e.addr = a;
      e.data = d; e.busy = bs; e.done = dn; e.err = er; e.code = ec;
      vecs.push_back(e);
   endtask

   task automatic q(input logic v, input logic [7:0] b, input logic bs);
      add(1'b0, v, b, 1'b0, 8'h00, 16'h0000, bs, 1'b0, 1'b0);
   endtask

   task automatic wr(input logic [7:0] b, input logic [7:0] a,
                     input logic [15:0] d);
      add(1'b0, 1'b1, b, 1'b1, a, d, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic ok(input logic [7:0] b);
      add(1'b0, 1'b1, b, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic bad(input logic v, input logic [7:0] b,
                      input logic [1:0] c);
      ec = c;
      add(1'b0, v, b, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic rst_row();
      ec = 2'b00;
      add(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk(input string nm, input int row,
                      input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
      end
   endtask

   task automatic fill();
      logic [7:0] i8;
      ec = 2'b00;
      // 1: good two-word frame
      rst_row();
      q(1, 8'hA5, 1); q(1, 8'h10, 1); q(1, 8'h02, 1); q(1, 8'h12, 1);
      wr(8'h34, 8'h10, 16'h1234); q(1, 8'h56, 1);
      wr(8'h78, 8'h11, 16'h5678); ok(8'hDA);
      // 2: bad checksum, writes still land
      q(1, 8'hA5, 1); q(1, 8'h10, 1); q(1, 8'h02, 1); q(1, 8'h12, 1);
      wr(8'h34, 8'h10, 16'h1234); q(1, 8'h56, 1);
      wr(8'h78, 8'h11, 16'h5678); bad(1, 8'hDB, ERR_CHECKSUM);
      // 3: address wrap
      q(1, 8'hA5, 1); q(1, 8'hFF, 1); q(1, 8'h02, 1); q(1, 8'h11, 1);
      wr(8'h22, 8'hFF, 16'h1122); q(1, 8'h33, 1);
      wr(8'h44, 8'h00, 16'h3344); ok(8'h55);
      // 4: timeout after DATA_HI, then a fresh frame
      q(1, 8'hA5, 1); q(1, 8'h00, 1); q(1, 8'h01, 1); q(1, 8'hAB, 1);
      for (int k = 0; k < TMO - 1; k++) q(0, 8'h00, 1);
      bad(0, 8'h00, ERR_TIMEOUT);
      q(0, 8'h00, 0);
      q(1, 8'hA5, 1); q(1, 8'h20, 1); q(1, 8'h01, 1); q(1, 8'hCA, 1);
      wr(8'hFE, 8'h20, 16'hCAFE); ok(8'h17);
      // 5: junk in IDLE, sync byte as data, byte exactly at expiry
      q(1, 8'h00, 0); q(1, 8'hFF, 0); q(1, 8'h3C, 0);
      q(1, 8'hA5, 1); q(1, 8'h40, 1); q(1, 8'h02, 1); q(1, 8'hA5, 1);
      wr(8'hA5, 8'h40, 16'hA5A5); q(1, 8'h00, 1);
      wr(8'h01, 8'h41, 16'h0001); ok(8'h73);
      q(1, 8'hA5, 1); q(1, 8'h50, 1); q(1, 8'h01, 1);
      for (int k = 0; k < TMO - 1; k++) q(0, 8'h00, 1);
      q(1, 8'h12, 1);
      wr(8'h34, 8'h50, 16'h1234); ok(8'h69);
      // 6: reset between DATA_HI and DATA_LO
      q(1, 8'hA5, 1); q(1, 8'h60, 1); q(1, 8'h01, 1); q(1, 8'h77, 1);
      rst_row();
      q(0, 8'h00, 0); q(1, 8'h88, 0);
      // COUNT=0: 256 words from 0x80, wrapping
      q(1, 8'hA5, 1); q(1, 8'h80, 1); q(1, 8'h00, 1);
      for (int k = 0; k < 256; k++) begin
         i8 = 8'(k);
         q(1, i8, 1);
         wr(~i8, 8'h80 + i8, {i8, ~i8});
      end
      ok(8'h80);
      q(0, 8'h00, 0);
   endtask

   initial begin
      rst = 1'b1;
      bv  = 1'b0;
      byt = 8'h00;
      fill();
      for (int r = 0; r < vecs.size(); r++) begin
         @(negedge clk);
         rst = vecs[r].rst;
         bv  = vecs[r].v;
         byt = vecs[r].b;
         @(posedge clk);
         #1;
         chk("wr_en", r, 16'(wr_en), 16'(vecs[r].wen));
         if (vecs[r].wen) begin
            chk("wr_addr", r, 16'(wr_addr), 16'(vecs[r].addr));
            chk("wr_data", r, wr_data, vecs[r].data);
         end
         if (vecs[r].rst) begin
            chk("rst_addr", r, 16'(wr_addr), 16'h0000);
            chk("rst_data", r, wr_data, 16'h0000);
         end
         chk("busy", r, 16'(busy), 16'(vecs[r].busy));
         chk("done", r, 16'(done), 16'(vecs[r].done));
         chk("error", r, 16'(err), 16'(vecs[r].err));
         chk("error_code", r, 16'(code), 16'(vecs[r].code));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
